serial_flow_adder: RTL and testbench

Parametrised serial-flow adder: the next generation of the fixed 3-bit-state serial adder/overflow block. It adds two LSB-first serial operand streams of a configurable word length and emits the serial sum with one cycle of latency. At the end of each word it reports overflow for either unsigned or two's-complement arithmetic. It adds explicit word framing, back-to-back word support and frame-error detection, and sits between the serial line receivers and the checker logic in the benchmark suite.

---
 rtl/serial_flow_pkg.sv | 15 +
 rtl/serial_flow_bitslice.sv | 73 +++++++
 rtl/serial_flow_adder.sv | 153 +++++++++++++++
 tb/tb_serial_flow_adder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_flow_pkg.sv
// Shared types and helpers for the serial flow adder.
package serial_flow_pkg;

  // Word framing FSM states
  typedef enum logic {
    IDLE = 1'b0,
    ADD  = 1'b1
  } state_t;

  // Bit-counter width for a word of w bits; never narrower than one bit
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_flow_bitslice.sv
// Bit-serial full adder with carry register and, when SFA_CMP_EN is
// defined, the running magnitude-comparator state.
module serial_flow_bitslice
  import serial_flow_pkg::*;
#(
  parameter bit SIGNED = 1'b0
) (
  input  logic clk,
  input  logic srst,
  input  logic consume,    // a bit is taken this cycle
  input  logic first_bit,  // this bit is bit 0 of a word
  input  logic a,
  input  logic b,
`ifdef SFA_CMP_EN
  input  logic msb,        // this bit is bit W-1 of a word
  output logic gt_next,
  output logic eq_next,
`endif
  output logic sum_bit,
  output logic carry_in,
  output logic carry_out
);

  logic carry_reg;

  // Full adder; carry chain restarts at bit 0 regardless of stored state
  always_comb begin
    carry_in  = first_bit ? 1'b0 : carry_reg;
    sum_bit   = a ^ b ^ carry_in;
    carry_out = (a & b) | (a & carry_in) | (b & carry_in);
  end

  // Carry register advances only on consumed bits
  always_ff @(posedge clk) begin
    if (srst) begin
      carry_reg <= 1'b0;
    end else if (consume) begin
      carry_reg <= carry_out;
    end
  end

`ifdef SFA_CMP_EN
  logic gt_reg;
  logic eq_reg;
  logic gt_base;
  logic eq_base;

  // Comparator: later (more significant) differing bits override earlier ones;
  // for two's complement the sign bit decides the other way round
  always_comb begin
    gt_base = first_bit ? 1'b0 : gt_reg;
    eq_base = first_bit ? 1'b1 : eq_reg;
    gt_next = gt_base;
    eq_next = eq_base;
    if (a != b) begin
      gt_next = (SIGNED && msb) ? b : a;
      eq_next = 1'b0;
    end
  end

  // Running comparator state, advanced on consumed bits
  always_ff @(posedge clk) begin
    if (srst) begin
      gt_reg <= 1'b0;
      eq_reg <= 1'b0;
    end else if (consume) begin
      gt_reg <= gt_next;
      eq_reg <= eq_next;
    end
  end
`endif

endmodule

// File: rtl/serial_flow_adder.sv
// Serial-flow adder: adds two LSB-first operand streams of W bits, emits the
// serial sum one cycle later, reports per-word overflow and frame errors.
// Optional feature macro: SFA_CMP_EN adds the GT_REG/EQ_REG comparator outputs.
module serial_flow_adder
  import serial_flow_pkg::*;
#(
  parameter int W      = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic clock,
  input  logic RESET_G,
  input  logic START,
  input  logic LINE1,
  input  logic LINE2,
  output logic OUTP_REG,
  output logic OUT_VALID,
  output logic WORD_DONE,
  output logic OVERFLW_REG,
  output logic FRAME_ERR
`ifdef SFA_CMP_EN
  ,
  output logic GT_REG,
  output logic EQ_REG
`endif
);

  localparam int CW = cnt_width(W);
  localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);

  state_t          state_reg;
  state_t          state_next;
  logic [CW-1:0]   cnt_reg;
  logic [CW-1:0]   cnt_next;
  logic            consume;
  logic            first_bit;
  logic            last_bit;
  logic            abort;
  logic            sum_bit;
  logic            carry_in;
  logic            carry_out;
  logic            ovf_bit;
`ifdef SFA_CMP_EN
  logic            gt_next;
  logic            eq_next;
`endif

  // Next-state logic: frame words on START, count bits, detect aborts
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    consume    = 1'b0;
    first_bit  = 1'b0;
    last_bit   = 1'b0;
    abort      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (START) begin
          consume    = 1'b1;
          first_bit  = 1'b1;
          state_next = ADD;
          cnt_next   = CW'(1);
        end
      end
      ADD: begin
        consume = 1'b1;
        if (START) begin
          // A fresh START mid-word abandons the current word
          abort      = 1'b1;
          first_bit  = 1'b1;
          cnt_next   = CW'(1);
        end else if (cnt_reg == LAST_IDX) begin
          last_bit   = 1'b1;
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next   = cnt_reg + CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // FSM state and bit counter
  always_ff @(posedge clock) begin
    if (RESET_G) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  serial_flow_bitslice #(
    .SIGNED (SIGNED)
  ) u_slice (
    .clk       (clock),
    .srst      (RESET_G),
    .consume   (consume),
    .first_bit (first_bit),
    .a         (LINE1),
    .b         (LINE2),
`ifdef SFA_CMP_EN
    .msb       (last_bit),
    .gt_next   (gt_next),
    .eq_next   (eq_next),
`endif
    .sum_bit   (sum_bit),
    .carry_in  (carry_in),
    .carry_out (carry_out)
  );

  // Overflow of the MSB: carry out, or carry-in xor carry-out for signed
  always_comb begin
    ovf_bit = SIGNED ? (carry_in ^ carry_out) : carry_out;
  end

  // Registered serial outputs and per-word flags
  always_ff @(posedge clock) begin
    if (RESET_G) begin
      OUTP_REG    <= 1'b0;
      OUT_VALID   <= 1'b0;
      WORD_DONE   <= 1'b0;
      OVERFLW_REG <= 1'b0;
      FRAME_ERR   <= 1'b0;
    end else begin
      OUTP_REG  <= consume & sum_bit;
      OUT_VALID <= consume;
      WORD_DONE <= last_bit;
      FRAME_ERR <= abort;
      if (last_bit) begin
        OVERFLW_REG <= ovf_bit;
      end
    end
  end

`ifdef SFA_CMP_EN
  // Comparator result latched only when a word completes
  always_ff @(posedge clock) begin
    if (RESET_G) begin
      GT_REG <= 1'b0;
      EQ_REG <= 1'b0;
    end else if (last_bit) begin
      GT_REG <= gt_next;
      EQ_REG <= eq_next;
    end
  end
`endif

endmodule

// File: tb/tb_serial_flow_adder.sv
// Scoreboard bench for serial_flow_adder: W=8 unsigned and signed instances
// share stimulus; a W=3 instance is exercised separately at the end.
module tb_serial_flow_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, l1, l2;
  logic start3, a3, b3;

  logic outp0, valid0, done0, ovf0, ferr0;
  logic outp1, valid1, done1, ovf1, ferr1;
  logic outp3, valid3, done3, ovf3, ferr3;
`ifdef SFA_CMP_EN
  logic gt0, eq0, gt1, eq1, gt3, eq3;
`endif

  serial_flow_adder #(.W(8), .SIGNED(1'b0)) dut0 (
    .clock(clk), .RESET_G(rst), .START(start), .LINE1(l1), .LINE2(l2),
    .OUTP_REG(outp0), .OUT_VALID(valid0), .WORD_DONE(done0),
    .OVERFLW_REG(ovf0), .FRAME_ERR(ferr0)
`ifdef SFA_CMP_EN
    , .GT_REG(gt0), .EQ_REG(eq0)
`endif
  );

  serial_flow_adder #(.W(8), .SIGNED(1'b1)) dut1 (
    .clock(clk), .RESET_G(rst), .START(start), .LINE1(l1), .LINE2(l2),
    .OUTP_REG(outp1), .OUT_VALID(valid1), .WORD_DONE(done1),
    .OVERFLW_REG(ovf1), .FRAME_ERR(ferr1)
`ifdef SFA_CMP_EN
    , .GT_REG(gt1), .EQ_REG(eq1)
`endif
  );

  serial_flow_adder #(.W(3), .SIGNED(1'b0)) dut3 (
    .clock(clk), .RESET_G(rst), .START(start3), .LINE1(a3), .LINE2(b3),
    .OUTP_REG(outp3), .OUT_VALID(valid3), .WORD_DONE(done3),
    .OVERFLW_REG(ovf3), .FRAME_ERR(ferr3)
`ifdef SFA_CMP_EN
    , .GT_REG(gt3), .EQ_REG(eq3)
`endif
  );

  typedef struct {
    bit         is_abort;
    logic [7:0] sum;
    bit         ovf;
    bit         ovf_s;
    bit         gt;
    bit         eq;
    bit         gt_s;
    bit         eq_s;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  // Monitor: collect serial sum bits, pop and compare on WORD_DONE / FRAME_ERR
  int         mcnt = 0;
  logic [7:0] acc  = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      mcnt = 0;
    end else begin
      if (ferr0) begin
        if (q.size() == 0) begin
          chk("unexpected_frame_err", 1, 0);
        end else begin
          e = q.pop_front();
          chk("abort_kind", {31'd0, e.is_abort}, 1);
          chk("abort_ovf_held", {31'd0, ovf0}, {31'd0, e.ovf});
          chk("abort_ovf_s_held", {31'd0, ovf1}, {31'd0, e.ovf_s});
        end
        mcnt = 0;
      end
      if (valid0) begin
        acc  = {outp0, acc[7:1]};
        mcnt = mcnt + 1;
      end
      if (done0) begin
        if (q.size() == 0) begin
          chk("unexpected_word_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("word_kind", {31'd0, e.is_abort}, 0);
          chk("word_bits", mcnt, 8);
          chk("sum", {24'd0, acc}, {24'd0, e.sum});
          chk("sum_signed_inst", {31'd0, outp1}, {31'd0, e.sum[7]});
          chk("ovf_unsigned", {31'd0, ovf0}, {31'd0, e.ovf});
          chk("ovf_signed", {31'd0, ovf1}, {31'd0, e.ovf_s});
          chk("done_signed_inst", {31'd0, done1}, 1);
`ifdef SFA_CMP_EN
          chk("gt_unsigned", {31'd0, gt0}, {31'd0, e.gt});
          chk("eq_unsigned", {31'd0, eq0}, {31'd0, e.eq});
          chk("gt_signed", {31'd0, gt1}, {31'd0, e.gt_s});
          chk("eq_signed", {31'd0, eq1}, {31'd0, e.eq_s});
`endif
        end
        mcnt = 0;
      end
    end
  end

  task automatic drive(input bit s, input bit a, input bit b);
    start = s;
    l1    = a;
    l2    = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom % 2), 1'($urandom % 2));
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input exp_t e);
    q.push_back(e);
    for (int i = 0; i < 8; i++) drive(i == 0, a[i], b[i]);
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_outp"}, {31'd0, outp0}, 0);
    chk({tag, "_valid"}, {31'd0, valid0}, 0);
    chk({tag, "_done"}, {31'd0, done0}, 0);
    chk({tag, "_ovf"}, {31'd0, ovf0}, 0);
    chk({tag, "_ferr"}, {31'd0, ferr0}, 0);
    chk({tag, "_ovf_s"}, {31'd0, ovf1}, 0);
`ifdef SFA_CMP_EN
    chk({tag, "_gt"}, {31'd0, gt0}, 0);
    chk({tag, "_eq"}, {31'd0, eq0}, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] s3;
    int         waited;
    rst = 1'b1; start = 1'b0; l1 = 1'b0; l2 = 1'b0;
    start3 = 1'b0; a3 = 1'b0; b3 = 1'b0;
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b1);      // START while in reset must be ignored
    check_all_zero("reset");
    chk("reset_w3_valid", {31'd0, valid3}, 0);
    rst = 1'b0;
    idle(2);
    chk("idle_valid", {31'd0, valid0}, 0);

    send(8'h5A, 8'h33, '{1'b0, 8'h8D, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
    idle(3);
    send(8'hFF, 8'h01, '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    send(8'h01, 8'h01, '{1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
    chk("b2b_valid_continuous", {31'd0, valid0}, 1);
    idle(2);
    send(8'hFF, 8'hFF, '{1'b0, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
    idle(2);
    chk("ovf_held_idle", {31'd0, ovf0}, 1);

    // Reset in the middle of a word (bit 3)
    for (int i = 0; i < 3; i++) drive(i == 0, 1'b1, 1'b1);
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b1);
    check_all_zero("midreset");
    rst = 1'b0;
    idle(1);
    send(8'h0F, 8'h0F, '{1'b0, 8'h1E, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
    idle(2);
    send(8'hFF, 8'hFF, '{1'b0, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
    idle(2);

    // Abort at bit index 4: four bits, then a new START
    q.push_back('{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    for (int i = 0; i < 4; i++) drive(i == 0, 1'b1, 1'b0);
    send(8'h10, 8'h20, '{1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    idle(3);

    // W=3 instance: 7+7
    for (int i = 0; i < 3; i++) begin
      start3 = (i == 0); a3 = 1'b1; b3 = 1'b1;
      @(posedge clk); #1;
      s3[i] = outp3;
    end
    start3 = 1'b0; a3 = 1'b0; b3 = 1'b0;
    chk("w3_sum", {29'd0, s3}, 32'h6);
    chk("w3_done", {31'd0, done3}, 1);
    chk("w3_ovf", {31'd0, ovf3}, 1);
`ifdef SFA_CMP_EN
    chk("w3_eq", {31'd0, eq3}, 1);
    chk("w3_gt", {31'd0, gt3}, 0);
`endif
    @(posedge clk); #1;
    chk("w3_done_pulse", {31'd0, done3}, 0);
    chk("w3_ovf_held", {31'd0, ovf3}, 1);

    waited = 0;
    while (q.size() != 0 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
